// File: rtl/elevator_car_ctrl.sv
// elevator_car_ctrl: single-car SCAN elevator controller with half-step
// positions, travel/door timers and two active-low 7-segment digits.
// Optional feature macro: ELEVATOR_REQ_LATCH_EN (sticky pending requests).
// state_dbg_o exposes the FSM state: 0 = IDLE, 1 = MOVE, 2 = DOOR.
module elevator_car_ctrl #(
    parameter int FLOORS        = 4,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [FLOORS-1:0]                request,
    output logic [FLOORS-1:0]                serviced,
    output logic [$clog2(2*FLOORS-1)-1:0]    position,
    output logic                             direction,
    output logic                             moving,
    output logic                             door_open,
    output logic [6:0]                       display1,
    output logic [6:0]                       display2,
    output logic [1:0]                       state_dbg_o
);
    localparam int POS_W = $clog2(2*FLOORS-1);
    localparam int FW    = POS_W - 1;
    localparam int TW    = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW    = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0]    TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0]    DOOR_LAST   = DW'(DOOR_CYCLES - 1);
    localparam logic [POS_W-1:0] TOP_POS     = POS_W'(2*FLOORS - 2);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MOVE = 2'd1, S_DOOR = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              dir_q, dir_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [DW-1:0]     door_q, door_d;
    logic [FLOORS-1:0] serviced_q, serviced_d;
    logic [6:0]        disp1_q, disp1_d, disp2_q, disp2_d;

    logic [FLOORS-1:0] eff_req;
    logic [POS_W-1:0]  step_pos;
    logic [FW-1:0]     cur_floor, land_floor;
    logic [FLOORS-1:0] cur_onehot, land_onehot;
    logic              req_above, req_below, land_ahead;

`ifdef ELEVATOR_REQ_LATCH_EN
    logic [FLOORS-1:0] pending_q, pending_d;
    assign eff_req = request | pending_q;
`else
    assign eff_req = request;
`endif

    assign cur_floor   = pos_q[POS_W-1:1];
    assign step_pos    = dir_q ? (pos_q + 1'b1) : (pos_q - 1'b1);
    assign land_floor  = step_pos[POS_W-1:1];
    assign cur_onehot  = FLOORS'(1) << cur_floor;
    assign land_onehot = FLOORS'(1) << land_floor;

    // Work-remaining flags relative to the current floor and to the floor about to be reached
    always_comb begin
        req_above  = 1'b0;
        req_below  = 1'b0;
        land_ahead = 1'b0;
        for (int f = 0; f < FLOORS; f++) begin
            if (eff_req[f] && (f > int'(cur_floor))) req_above = 1'b1;
            if (eff_req[f] && (f < int'(cur_floor))) req_below = 1'b1;
            if (eff_req[f] && (dir_q ? (f > int'(land_floor)) : (f < int'(land_floor))))
                land_ahead = 1'b1;
        end
    end

    // State, position, timers and registered outputs; reset parks the car at floor 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pos_q      <= '0;
            dir_q      <= 1'b1;
            timer_q    <= '0;
            door_q     <= '0;
            serviced_q <= '0;
            disp1_q    <= 7'b1111001;
            disp2_q    <= 7'b1111111;
`ifdef ELEVATOR_REQ_LATCH_EN
            pending_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            timer_q    <= timer_d;
            door_q     <= door_d;
            serviced_q <= serviced_d;
            disp1_q    <= disp1_d;
            disp2_q    <= disp2_d;
`ifdef ELEVATOR_REQ_LATCH_EN
            pending_q  <= pending_d;
`endif
        end
    end

    // SCAN decision: serve here first, keep heading while work is ahead, else reverse
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        dir_d      = dir_q;
        timer_d    = '0;
        door_d     = '0;
        serviced_d = '0;
        case (state_q)
            S_IDLE: begin
                if (eff_req[cur_floor]) begin
                    state_d    = S_DOOR;
                    serviced_d = cur_onehot;
                end else if (dir_q && req_above) begin
                    state_d = S_MOVE;
                end else if (req_below) begin
                    state_d = S_MOVE;
                    dir_d   = 1'b0;
                end else if (req_above) begin
                    state_d = S_MOVE;
                    dir_d   = 1'b1;
                end
            end
            S_MOVE: begin
                if (timer_q == TRAVEL_LAST) begin
                    pos_d = step_pos;
                    if (step_pos[0]) begin
                        state_d = S_MOVE;           // never stop between floors
                    end else if (eff_req[land_floor]) begin
                        state_d    = S_DOOR;
                        serviced_d = land_onehot;
                    end else if (land_ahead) begin
                        state_d = S_MOVE;
                    end else begin
                        state_d = S_IDLE;           // request withdrawn en route
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DOOR: begin
                if (door_q == DOOR_LAST) state_d = S_IDLE;
                else                     door_d  = door_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // The end floors only allow one way out
        if (pos_d == '0)          dir_d = 1'b1;
        else if (pos_d == TOP_POS) dir_d = 1'b0;
`ifdef ELEVATOR_REQ_LATCH_EN
        pending_d = (pending_q | request) & ~serviced_d;
        if (state_q == S_DOOR) pending_d = pending_d & ~cur_onehot;  // absorb presses while open
`endif
    end

    // Status outputs and the display decode of the next position
    always_comb begin
        moving      = (state_q == S_MOVE);
        door_open   = (state_q == S_DOOR);
        state_dbg_o = state_q;
        case (4'(pos_d[POS_W-1:1]))
            4'd0:    disp1_d = 7'b1111001;
            4'd1:    disp1_d = 7'b0100100;
            4'd2:    disp1_d = 7'b0110000;
            4'd3:    disp1_d = 7'b0011001;
            4'd4:    disp1_d = 7'b0010010;
            4'd5:    disp1_d = 7'b0000010;
            4'd6:    disp1_d = 7'b1111000;
            4'd7:    disp1_d = 7'b0000000;
            4'd8:    disp1_d = 7'b0010000;
            default: disp1_d = 7'b1111111;
        endcase
        disp2_d = pos_d[0] ? 7'b0001001 : 7'b1111111;
    end

    assign serviced  = serviced_q;
    assign position  = pos_q;
    assign direction = dir_q;
    assign display1  = disp1_q;
    assign display2  = disp2_q;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// tb_elevator_car_ctrl: directed scenarios for elevator_car_ctrl with a
// behavioural reference model checked every cycle, plus literal spot checks.
module tb_elevator_car_ctrl;
    localparam int NF = 4;
    localparam int TC = 4;
    localparam int DC = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NF-1:0] req_hold = '0;
    logic [NF-1:0] req_pulse = '0;
    logic [NF-1:0] request;
    logic [NF-1:0] serviced;
    logic [2:0]    position;
    logic          direction, moving, door_open;
    logic [6:0]    display1, display2;
    logic [1:0]    state_dbg;

    assign request = req_hold | req_pulse;

    elevator_car_ctrl #(.FLOORS(NF), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .request(request), .serviced(serviced),
        .position(position), .direction(direction), .moving(moving),
        .door_open(door_open), .display1(display1), .display2(display2),
        .state_dbg_o(state_dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit run_cmp  = 1'b0;
    logic [NF-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1111001;  1: return 7'b0100100;  2: return 7'b0110000;
            3: return 7'b0011001;  4: return 7'b0010010;  5: return 7'b0000010;
            6: return 7'b1111000;  7: return 7'b0000000;  8: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // reference model: mode 0 idle, 1 travelling, 2 door open; m_left counts cycles remaining
    int            m_mode, m_pos, m_left;
    bit            m_dir;
    logic [NF-1:0] m_pend, m_srv;

    always @(posedge clk or posedge reset) begin
        logic [NF-1:0] p;
        int  f;
        bit  above, below, ahead, was_door;
        if (reset) begin
            m_mode = 0; m_pos = 0; m_dir = 1'b1; m_left = 0; m_pend = '0; m_srv = '0;
        end else begin
`ifdef ELEVATOR_REQ_LATCH_EN
            p = request | m_pend;
`else
            p = request;
`endif
            m_srv = '0;
            was_door = (m_mode == 2);
            f = m_pos / 2;
            if (m_mode == 0) begin
                above = 0; below = 0;
                for (int i = 0; i < NF; i++) begin
                    if (p[i] && i > f) above = 1;
                    if (p[i] && i < f) below = 1;
                end
                if (p[f]) begin m_mode = 2; m_left = DC; m_srv[f] = 1'b1; end
                else if (m_dir && above) begin m_mode = 1; m_left = TC; end
                else if (below) begin m_mode = 1; m_left = TC; m_dir = 1'b0; end
                else if (above) begin m_mode = 1; m_left = TC; m_dir = 1'b1; end
            end else if (m_mode == 1) begin
                m_left--;
                if (m_left == 0) begin
                    m_pos = m_pos + (m_dir ? 1 : -1);
                    m_left = TC;
                    if (m_pos % 2 == 0) begin
                        f = m_pos / 2;
                        ahead = 0;
                        for (int i = 0; i < NF; i++)
                            if (p[i] && (m_dir ? (i > f) : (i < f))) ahead = 1;
                        if (p[f]) begin m_mode = 2; m_left = DC; m_srv[f] = 1'b1; end
                        else if (!ahead) m_mode = 0;
                    end
                end
            end else begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
            if (m_pos == 0) m_dir = 1'b1;
            if (m_pos == 2*NF-2) m_dir = 1'b0;
`ifdef ELEVATOR_REQ_LATCH_EN
            m_pend = (m_pend | request) & ~m_srv;
            if (was_door) m_pend[m_pos/2] = 1'b0;
`endif
        end
    end

    // scoreboard / compare process on the falling edge
    always @(negedge clk) begin
        if (run_cmp) begin
            check("serviced",  serviced,  m_srv);
            check("position",  position,  m_pos);
            check("direction", direction, m_dir);
            check("moving",    moving,    m_mode == 1);
            check("door_open", door_open, m_mode == 2);
            check("state",     state_dbg, m_mode);
            check("display1",  display1,  seg(m_pos / 2));
            check("display2",  display2,  (m_pos % 2) ? 7'b0001001 : 7'b1111111);
            if (serviced != '0) begin
                if (exp_q.size() == 0) check("srv_unexpected", serviced, 0);
                else check("srv_order", serviced, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        req_pulse = '0;
        req_hold  = req_hold & ~m_srv;
    endtask

    task automatic press(input logic [NF-1:0] m);
`ifdef ELEVATOR_REQ_LATCH_EN
        req_pulse = req_pulse | m;
`else
        req_hold = req_hold | m;
`endif
    endtask

    task automatic tap(input logic [NF-1:0] m);
        req_pulse = req_pulse | m;
    endtask

    task automatic wait_service(input string name, input int budget);
        int n = 0;
        do begin tick(); n++; end while (m_srv == '0 && n < budget);
        check({name, "_timeout"}, (m_srv == '0), 0);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        do begin tick(); n++; end while (m_mode != 0 && n < budget);
        check({name, "_timeout"}, (m_mode != 0), 0);
    endtask

    task automatic wait_pos(input string name, input int pos, input int budget);
        int n = 0;
        do begin tick(); n++; end while (m_pos != pos && n < budget);
        check({name, "_timeout"}, (m_pos != pos), 0);
    endtask

    initial begin
        int n_open;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        run_cmp = 1'b1;
        check("rst_position", position, 0);
        check("rst_direction", direction, 1);
        check("rst_display1", display1, 7'b1111001);
        check("rst_display2", display2, 7'b1111111);
        check("rst_moving", moving, 0);
        check("rst_door", door_open, 0);
        check("rst_serviced", serviced, 0);

        // single trip floor 0 -> floor 2, edge numbering from the press
        tick();
        press(4'b0100);
        exp_q.push_back(4'b0100);
        for (int e = 1; e <= 25; e++) begin
            tick();
            case (e)
                1:  check("s1_moving_e1", moving, 1);
                5:  begin check("s1_pos_e5", position, 1); check("s1_h_e5", display2, 7'b0001001); end
                9:  begin check("s1_pos_e9", position, 2); check("s1_d1_e9", display1, 7'b0100100);
                          check("s1_blank_e9", display2, 7'b1111111); end
                13: begin check("s1_pos_e13", position, 3); check("s1_h_e13", display2, 7'b0001001); end
                17: begin check("s1_pos_e17", position, 4); check("s1_srv_e17", serviced, 4'b0100);
                          check("s1_door_e17", door_open, 1); end
                18: check("s1_srv_e18", serviced, 0);
                24: check("s1_door_e24", door_open, 1);
                25: begin check("s1_door_e25", door_open, 0); check("s1_moving_e25", moving, 0); end
                default: ;
            endcase
        end

        // at floor 2: current floor and floor 3 together -> open here first, then go up
        press(4'b1100);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        tick();
        check("s3_srv_here", serviced, 4'b0100);
        check("s3_door_here", door_open, 1);
        check("s3_pos_here", position, 4);
        wait_service("s3_top", 100);
        check("s3_srv_top", serviced, 4'b1000);
        check("s3_dir_top", direction, 0);

        // press for the current floor while the door is open: absorbed, dwell unchanged
        n_open = 0;
        for (int i = 0; i < 3; i++) begin if (door_open) n_open++; tick(); end
        tap(4'b1000);
        for (int i = 0; i < 20 && door_open; i++) begin n_open++; tick(); end
        check("absorb_dwell", n_open, DC);
        repeat (12) tick();
        check("absorb_no_reopen", door_open, 0);
        check("absorb_pos", position, 6);

        // SCAN: at floor 1 heading up with floors 0 and 3 requested
        reset = 1'b1;
        tick();
        reset = 1'b0;
        press(4'b0010);
        exp_q.push_back(4'b0010);
        wait_service("s2_f1", 100);
        wait_idle("s2_f1_idle", 20);
        check("s2_start_pos", position, 2);
        check("s2_start_dir", direction, 1);
        press(4'b1001);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        wait_service("s2_first", 100);
        check("s2_first_srv", serviced, 4'b1000);
        wait_service("s2_second", 200);
        check("s2_second_srv", serviced, 4'b0001);
        check("s2_second_pos", position, 0);
        wait_idle("s2_idle", 20);

        // asynchronous reset in the middle of travel
        press(4'b1000);
        wait_pos("rst_mid", 3, 100);
        req_hold = '0;
        #2 reset = 1'b1;
        #1;
        check("rstmid_pos", position, 0);
        check("rstmid_moving", moving, 0);
        check("rstmid_dir", direction, 1);
        tick();
        reset = 1'b0;
        repeat (20) tick();
        check("rstmid_pending_lost", moving, 0);
        check("rstmid_stay", position, 0);

`ifndef ELEVATOR_REQ_LATCH_EN
        // level request withdrawn mid-travel -> stop idle at the next floor
        press(4'b1000);
        wait_pos("wd", 3, 100);
        req_hold = '0;
        wait_idle("wd_idle", 20);
        check("wd_pos", position, 4);
        check("wd_moving", moving, 0);
        check("wd_door", door_open, 0);
        repeat (10) tick();
        check("wd_stay", position, 4);
`endif

        check("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/elevator_car_ctrl.md
# elevator_car_ctrl

Parametrised single-car elevator controller for N floors with half-step positions between floors. It takes a floor-request bitmask, runs a SCAN (keep going in the current direction while work remains) policy, and times car travel and door dwell. It drives two active-low 7-segment digits showing floor number and between-floor "H" marker. The block sits between the request-button/debounce logic and the board display/LED drivers.

## Interface
- FLOORS, 4, number of floors; legal range 2..9.
- TRAVEL_CYCLES, 4, clock cycles per half-step (floor to mid-point); ≥1.
- DOOR_CYCLES, 8, cycles the door stays open per stop; ≥1.
- POS_W, derived $clog2(2*FLOORS-1), position width (localparam).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- request  in  FLOORS  bit f = floor f (0-based) requested.
- serviced  out  FLOORS  one-hot, one-cycle pulse on door opening at floor f.
- position  out  POS_W  0..2*FLOORS-2; even = at floor position/2, odd = between floors.
- direction  out  1  1 = up, 0 = down.
- moving  out  1  high in MOVE.
- door_open  out  1  high in DOOR.
- display1  out  7  floor digit (position/2)+1, active-low, {g,f,e,d,c,b,a}.
- display2  out  7  "H" (0001001) when position odd, else blank (1111111).

## Operation
- Effective request set P: request | pending with the macro; request alone without it.
- States: IDLE, MOVE, DOOR.
- IDLE at floor f:
  - If P[f], go to DOOR and pulse serviced[f]. This takes priority over moving.
  - Otherwise, if direction=1 and any P above f, go to MOVE up.
  - Otherwise, if any P below f, go to MOVE with direction=0.
  - Otherwise, if any P above f, go to MOVE with direction=1.
  - Otherwise stay in IDLE.
- MOVE: the timer counts 0..TRAVEL_CYCLES-1. On the terminal count, position steps ±1 by direction and the timer returns to 0.
  - Landing on an odd position: always continue in MOVE. The car never stops mid-floor.
  - Landing on an even position g with P[g]: go to DOOR on that same edge and pulse serviced[g].
  - Landing on even g without P[g], with P still ahead in direction: continue in MOVE.
  - Landing on even g with nothing ahead (level request withdrawn): go to IDLE.
- DOOR: the counter runs for DOOR_CYCLES cycles, then the block goes to IDLE. Requests for the current floor during DOOR are absorbed: pending bit cleared, no re-open, no extra serviced pulse.
- Direction is forced to 0 at the top floor and to 1 at floor 0.
- Displays are a registered decode of position. Codes for digits 1–9: 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.

## Timing
- Reset values:
  - state IDLE, position 0, direction 1, moving 0, door_open 0, serviced 0.
  - display1 1111001, display2 1111111, pending 0, timers 0.
- Reset asserted mid-MOVE or mid-DOOR: the car returns to floor 0 asynchronously and all pending requests are lost.
- Decision latency: a request sampled at edge k gives MOVE or DOOR outputs after edge k.
- Travel time is 2*TRAVEL_CYCLES cycles per floor. Door dwell is exactly DOOR_CYCLES cycles.
- serviced is high for exactly the first DOOR cycle.
- A request arriving on the same edge as a floor is passed:
  - it is honoured if it is in P when the position lands on that floor;
  - otherwise it is served on a later sweep.

## Configuration
- ELEVATOR_REQ_LATCH_EN:
  - Defined: request bits are sticky in an internal pending register (pending <= pending | request), and a bit is cleared on the cycle its serviced pulse fires. A single-cycle button pulse is sufficient.
  - Undefined: no pending register; request is level-sensitive and must be held by upstream logic until serviced.

## Test plan
- Reset with FLOORS=4, TRAVEL_CYCLES=4, DOOR_CYCLES=8 -> position 0, direction 1, display1 1111001, display2 1111111, all other outputs 0.
- request=0100 pulsed for 1 cycle (latch on) at edge 0:
  - MOVE from edge 1; position 1,2,3,4 at edges 5,9,13,17.
  - DOOR and serviced=0100 at edge 17; door_open low and IDLE at edge 25.
  - display2 = H while position is 1 or 3.
- Car at floor 1 (position 2), direction 1, pending {0,3}: serves floor 3 first, then reverses and serves floor 0. Two serviced pulses in order 1000 then 0001.
- At floor 2 in IDLE, request=0100 and 1000 simultaneously -> door opens at floor 2 first (serviced=0100); then moves up.
- Request for the current floor during DOOR -> no second serviced pulse, dwell unchanged.
- Reset asserted mid-MOVE at position 3 -> immediately position 0, moving 0, pending 0. Without the macro, releasing a level request mid-travel -> IDLE at the next even position.
